// File: rtl/npu_host_master_if.sv
// npu_host_master_if: command/response stream plus NPU host port
// (ena/wea/addra/dina/douta) used by npu_host_master.
// master modport is the initiator's view; slave is the sequencer/NPU side.
interface npu_host_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, douta,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, ena, wea, addra, dina, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, douta,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, ena, wea, addra, dina, busy
  );
endinterface

// File: rtl/npu_host_master.sv
// npu_host_master: bus initiator for the NPU host port. Executes single
// writes, single reads, done-bit polls and timed delays from a command
// stream; read and poll results return on a valid/ready response.
// Optional build macro NPU_HOST_POLL_TIMEOUT_EN bounds each poll to
// POLL_MAX strobes and reports expiry on rsp_err; without it polling is
// unbounded and rsp_err is constant 0.
module npu_host_master #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned POLL_MAX = 1024,
  parameter int unsigned DLY_W    = 16
) (
  input logic               clk,
  input logic               rst_ni,
  npu_host_master_if.master bus
);

  // Shared counter for read-latency and poll-gap waits.
  localparam int unsigned CNT_MAX = (RD_LAT > POLL_GAP) ? RD_LAT : POLL_GAP;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  if (RD_LAT < 1 || POLL_MAX < 1 || DLY_W > DATA_W) begin : g_bad_param
    $error("npu_host_master: RD_LAT and POLL_MAX must be >= 1, DLY_W <= DATA_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_STROBE,
    S_RD_WAIT,
    S_POLL_GAP,
    S_DELAY,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_DELAY = 2'b11
  } cmd_op_e;

  state_e            state_q;
  logic              ena_q;
  logic              wea_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              poll_q;
  logic [DATA_W-1:0] mask_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DLY_W-1:0]  dly_q;
  logic              poll_hit;
  logic              poll_expired;

`ifdef NPU_HOST_POLL_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);
  logic [PCNT_W-1:0] poll_cnt_q;

  // Strobe count is updated in the strobe cycle, so at sample time it
  // already includes the strobe that produced the sample.
  assign poll_expired = (poll_cnt_q >= PCNT_W'(POLL_MAX));
`else
  assign poll_expired = 1'b0;
`endif

  // A mask of zero can never hit; only expiry (if built) ends such a poll.
  assign poll_hit = ((bus.douta & mask_q) != '0);

  // Command sequencer: state, host-port strobes and response registers.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      poll_q      <= 1'b0;
      mask_q      <= '0;
      cnt_q       <= '0;
      dly_q       <= '0;
`ifdef NPU_HOST_POLL_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            case (cmd_op_e'(bus.cmd_op))
              OP_WRITE: begin
                state_q <= S_WRITE;
                ena_q   <= 1'b1;
                wea_q   <= 1'b1;
                addra_q <= bus.cmd_addr;
                dina_q  <= bus.cmd_data;
              end
              OP_READ, OP_POLL: begin
                state_q <= S_RD_STROBE;
                ena_q   <= 1'b1;
                wea_q   <= 1'b0;
                addra_q <= bus.cmd_addr;
                dina_q  <= '0;
                poll_q  <= (bus.cmd_op == OP_POLL);
                mask_q  <= bus.cmd_data;
`ifdef NPU_HOST_POLL_TIMEOUT_EN
                poll_cnt_q <= '0;
`endif
              end
              OP_DELAY: begin
                state_q <= S_DELAY;
                dly_q   <= bus.cmd_data[DLY_W-1:0];
              end
            endcase
          end
        end

        S_WRITE: begin
          ena_q   <= 1'b0;
          wea_q   <= 1'b0;
          state_q <= S_IDLE;
        end

        S_RD_STROBE: begin
          ena_q   <= 1'b0;
          cnt_q   <= CNT_W'(RD_LAT - 1);
          state_q <= S_RD_WAIT;
`ifdef NPU_HOST_POLL_TIMEOUT_EN
          poll_cnt_q <= poll_cnt_q + 1'b1;
`endif
        end

        S_RD_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!poll_q || poll_hit || poll_expired) begin
            rsp_data_q  <= bus.douta;
            rsp_err_q   <= poll_q && !poll_hit && poll_expired;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (POLL_GAP == 0) begin
            ena_q   <= 1'b1;
            state_q <= S_RD_STROBE;
          end else begin
            cnt_q   <= CNT_W'(POLL_GAP - 1);
            state_q <= S_POLL_GAP;
          end
        end

        S_POLL_GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            ena_q   <= 1'b1;
            state_q <= S_RD_STROBE;
          end
        end

        // A zero count still spends one cycle here, matching the write timing.
        S_DELAY: begin
          if (dly_q <= DLY_W'(1)) begin
            state_q <= S_IDLE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.ena       = ena_q;
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_npu_host_master.sv
// Directed bench for npu_host_master with a two-cycle-latency host memory model.
`timescale 1ns/1ps
module tb_npu_host_master;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  npu_host_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  npu_host_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .POLL_GAP(4),
    .POLL_MAX(4), .DLY_W(16)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_num = 0;
  int wr_cnt = 0;
  int ena_cnt = 0;
  int strobe_at [64];
  int mode = 0;
  int rd_base = 0;
  int c0 = 0;
  int e0 = 0;
  int w0 = 0;
  logic [31:0] stage1 = '0;
  logic [31:0] stage2 = '0;

  assign bus.douta = stage2;

  // Host memory model: data for a read strobe in cycle C is on douta in C+2.
  // mode 0: constant 0xDEADBEEF; mode 1: bit0 set from the 3rd read on;
  // mode 2: read k returns k<<8 (bit0 never set).
  always @(posedge clk) begin
    if (bus.ena && !bus.wea) begin
      rd_num = rd_num + 1;
      strobe_at[rd_num % 64] = cyc;
      case (mode)
        0: stage1 <= 32'hDEAD_BEEF;
        1: stage1 <= ((rd_num - rd_base) >= 3) ? 32'h0000_0003 : 32'h0000_0000;
        default: stage1 <= 32'((rd_num - rd_base) << 8);
      endcase
    end else begin
      stage1 <= 32'h0;
    end
    if (bus.ena && bus.wea) wr_cnt = wr_cnt + 1;
    if (bus.ena) ena_cnt = ena_cnt + 1;
    stage2 <= stage1;
    cyc = cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] data);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_at_issue", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lim);
    int w;
    w = 0;
    while (bus.rsp_valid !== 1'b1 && w < lim) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic reset_pulse(input string tag);
    rst_ni = 1'b0;
    #1;
    chk({tag, "_ena"},       32'(bus.ena),       32'd0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ena",       32'(bus.ena),       32'd0);
    chk("rst_wea",       32'(bus.wea),       32'd0);
    chk("rst_addra",     32'(bus.addra),     32'd0);
    chk("rst_dina",      bus.dina,           32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  bus.rsp_data,       32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);

    // Single write: one strobe cycle at T+1, ready again at T+2
    w0 = wr_cnt;
    issue(2'b00, 16'h1000, 32'h0403_0201);
    chk("wr_ena",       32'(bus.ena),       32'd1);
    chk("wr_wea",       32'(bus.wea),       32'd1);
    chk("wr_addra",     32'(bus.addra),     32'h1000);
    chk("wr_dina",      bus.dina,           32'h0403_0201);
    chk("wr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("wr_ena_off",    32'(bus.ena),       32'd0);
    chk("wr_wea_off",    32'(bus.wea),       32'd0);
    chk("wr_ready_t2",   32'(bus.cmd_ready), 32'd1);
    chk("wr_no_rsp",     32'(bus.rsp_valid), 32'd0);
    chk("wr_strobe_cnt", 32'(wr_cnt - w0),   32'd1);

    // Single read with a response held for 5 cycles of rsp_ready=0
    mode = 0;
    rd_base = rd_num;
    issue(2'b01, 16'h5004, 32'h0);
    c0 = cyc;
    chk("rd_ena",   32'(bus.ena),   32'd1);
    chk("rd_wea",   32'(bus.wea),   32'd0);
    chk("rd_addra", 32'(bus.addra), 32'h5004);
    chk("rd_dina",  bus.dina,       32'd0);
    @(negedge clk);
    chk("rd_ena_off", 32'(bus.ena),       32'd0);
    chk("rd_nv_c1",   32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("rd_nv_c2",   32'(bus.rsp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rd_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_hold_data",  bus.rsp_data,       32'hDEAD_BEEF);
    end
    chk("rd_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("rd_still_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rd_rsp_done",    32'(bus.rsp_valid),          32'd0);
    chk("rd_idle",        32'(bus.cmd_ready),          32'd1);
    chk("rd_strobes",     32'(rd_num - rd_base),       32'd1);
    chk("rd_strobe_cyc",  32'(strobe_at[(rd_base + 1) % 64] - c0), 32'd0);

    // Poll: bit0 appears on the 3rd read, strobes 7 cycles apart
    mode = 1;
    rd_base = rd_num;
    issue(2'b10, 16'h5000, 32'h1);
    c0 = cyc;
    wait_rsp(60);
    chk("poll_valid",   32'(bus.rsp_valid),    32'd1);
    chk("poll_latency", 32'(cyc - c0),         32'd17);
    chk("poll_strobes", 32'(rd_num - rd_base), 32'd3);
    chk("poll_s2",      32'(strobe_at[(rd_base + 2) % 64] - c0), 32'd7);
    chk("poll_s3",      32'(strobe_at[(rd_base + 3) % 64] - c0), 32'd14);
    chk("poll_data",    bus.rsp_data,          32'h3);
    chk("poll_err",     32'(bus.rsp_err),      32'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("poll_done", 32'(bus.rsp_valid), 32'd0);

`ifdef NPU_HOST_POLL_TIMEOUT_EN
    // Poll that never matches expires after POLL_MAX=4 strobes
    mode = 2;
    rd_base = rd_num;
    issue(2'b10, 16'h5000, 32'h1);
    c0 = cyc;
    wait_rsp(80);
    chk("to_valid",   32'(bus.rsp_valid),    32'd1);
    chk("to_latency", 32'(cyc - c0),         32'd24);
    chk("to_strobes", 32'(rd_num - rd_base), 32'd4);
    chk("to_s4",      32'(strobe_at[(rd_base + 4) % 64] - c0), 32'd21);
    chk("to_err",     32'(bus.rsp_err),      32'd1);
    chk("to_data",    bus.rsp_data,          32'h0000_0400);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("to_done", 32'(bus.rsp_valid), 32'd0);
    mode = 0;
    rd_base = rd_num;
    issue(2'b10, 16'h5008, 32'h0);
`else
    // Poll with mask 0 runs unbounded until reset
    mode = 0;
    rd_base = rd_num;
    issue(2'b10, 16'h5008, 32'h0);
    c0 = cyc;
    repeat (40) @(negedge clk);
    chk("hang_no_rsp",  32'(bus.rsp_valid),    32'd0);
    chk("hang_busy",    32'(bus.busy),         32'd1);
    chk("hang_err",     32'(bus.rsp_err),      32'd0);
    chk("hang_strobes", 32'(rd_num - rd_base), 32'd6);
`endif

    // Reset asserted during a poll strobe cycle
    for (int i = 0; i < 20 && bus.ena !== 1'b1; i++) @(negedge clk);
    chk("pollrst_ena_seen", 32'(bus.ena), 32'd1);
    reset_pulse("pollrst");

    // Delay N=10, then N=0 (upper data bits ignored)
    e0 = ena_cnt;
    issue(2'b11, 16'h0, 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk("dly_busy",  32'(bus.busy),      32'd1);
      chk("dly_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    chk("dly_end_ready", 32'(bus.cmd_ready), 32'd1);
    chk("dly_end_busy",  32'(bus.busy),      32'd0);
    chk("dly_no_ena",    32'(ena_cnt - e0),  32'd0);
    issue(2'b11, 16'h0, 32'hFFFF_0000);
    chk("dly0_busy_t1",  32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("dly0_ready_t2", 32'(bus.cmd_ready), 32'd1);

    // Reset during S_RD_WAIT discards the read
    mode = 0;
    issue(2'b01, 16'h5004, 32'h0);
    @(negedge clk);
    reset_pulse("rdwait_rst");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rdwait_no_stale", 32'(bus.rsp_valid), 32'd0);
    end

    // Reset while a response is pending
    issue(2'b01, 16'h5004, 32'h0);
    wait_rsp(10);
    chk("pend_valid", 32'(bus.rsp_valid), 32'd1);
    reset_pulse("pend_rst");
    chk("pend_data_cleared", bus.rsp_data, 32'd0);

    // Normal read after reset
    rd_base = rd_num;
    issue(2'b01, 16'h5004, 32'h0);
    c0 = cyc;
    wait_rsp(10);
    chk("post_latency", 32'(cyc - c0),  32'd3);
    chk("post_data",    bus.rsp_data,   32'hDEAD_BEEF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_done", 32'(bus.cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
